// File: rtl/execute_stage_pkg.sv
// Shared micro-architecture definitions for the execute stage: opcodes, ctrl
// bit positions, flag bit indices and FSM state encodings.
package execute_stage_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_SAR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_MOV = 4'd9;

   localparam int CTRL_IMM_SEL = 6;
   localparam int CTRL_WB      = 5;
   localparam int CTRL_FLAGS   = 4;

   localparam int FLAG_CF = 0;
   localparam int FLAG_ZF = 1;
   localparam int FLAG_SF = 2;
   localparam int FLAG_OF = 3;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MUL      = 2'd1;
   localparam logic [1:0] ST_MUL_DONE = 2'd2;

   // Flags register layout is {OF,SF,ZF,CF}.
   function automatic logic [3:0] pack_flags(input logic of, input logic sf,
                                             input logic zf, input logic cf);
      logic [3:0] f;
      f = '0;
      f[FLAG_OF] = of;
      f[FLAG_SF] = sf;
      f[FLAG_ZF] = zf;
      f[FLAG_CF] = cf;
      return f;
   endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, full
// 2*WIDTH-bit product after CYCLES steps.
module mul_iter #(
   parameter int WIDTH  = 32,
   parameter int CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               step,
   input  logic               clear,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [2*WIDTH-1:0] product_next
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   // product_next is what the accumulator holds after the current step, so the
   // caller can capture the finished product on the same edge as the last step.
   assign product_next = product + (mplier[0] ? mcand : '0);
   assign done         = (count == CW'(CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (start) begin
         product <= '0;
         mcand   <= {{WIDTH{1'b0}}, a};
         mplier  <= b;
         count   <= '0;
      end else if (step) begin
         product <= product_next;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         count   <= count + 1'b1;
      end
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative multiply and flags register,
// producing a registered writeback packet with valid/ready on both sides.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NREG_BITS  = 3,
   parameter int MUL_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           ctrl,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic [NREG_BITS-1:0] dst_idx,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_we,
   output logic [NREG_BITS-1:0] out_widx,
   output logic [WIDTH-1:0]     out_wdata,
   output logic [3:0]           flags
);

   localparam int SHW = $clog2(WIDTH);

   logic [1:0] state;
   logic [3:0] opcode;
   logic       out_free, accept, is_mul, arch_op;
   logic       out_wb;
   logic       unused_imm_sel;

   assign opcode         = ctrl[3:0];
   assign is_mul         = (opcode == OP_MUL);
   assign arch_op        = (opcode <= OP_MOV);
   assign unused_imm_sel = ctrl[CTRL_IMM_SEL];

   assign out_free = !out_valid || out_ready;
   assign in_ready = !rst && (state == ST_IDLE) && out_free && !flush;
   assign accept   = in_valid && in_ready;
   assign out_we   = out_valid && out_wb;

   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   sum, diff, shl_ext, shr_ext, sar_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cf, alu_of;

   // Shifts run one bit wider so the last bit shifted out lands in the extra bit.
   assign amt     = op_b[SHW-1:0];
   assign sum     = {1'b0, op_a} + {1'b0, op_b};
   assign diff    = {1'b0, op_a} - {1'b0, op_b};
   assign shl_ext = {1'b0, op_a} << amt;
   assign shr_ext = {op_a, 1'b0} >> amt;
   assign sar_ext = $signed({op_a, 1'b0}) >>> amt;

   always_comb begin
      alu_res = '0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_cf  = sum[WIDTH];
            alu_of  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_cf  = diff[WIDTH];
            alu_of  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_XOR: alu_res = op_a ^ op_b;
         OP_SHL: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_cf  = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_ext[WIDTH:1];
            alu_cf  = shr_ext[0];
         end
         OP_SAR: begin
            alu_res = sar_ext[WIDTH:1];
            alu_cf  = sar_ext[0];
         end
         OP_MOV: alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   logic                 mul_start, mul_step, mul_done;
   logic [2*WIDTH-1:0]   mul_product, mul_product_next, mul_p;
   logic [NREG_BITS-1:0] mul_dst;
   logic                 mul_wb, mul_flag_en;

   assign mul_start = accept && is_mul;
   assign mul_step  = (state == ST_MUL) && !flush;

   mul_iter #(
      .WIDTH (WIDTH),
      .CYCLES(MUL_CYCLES)
   ) u_mul (
      .clk         (clk),
      .rst         (rst),
      .start       (mul_start),
      .step        (mul_step),
      .clear       (flush),
      .a           (op_a),
      .b           (op_b),
      .done        (mul_done),
      .product     (mul_product),
      .product_next(mul_product_next)
   );

   // In MUL the final step's sum is captured directly; MUL_DONE holds it in the multiplier.
   assign mul_p = (state == ST_MUL) ? mul_product_next : mul_product;

   logic                 load_mul, load_single, load;
   logic [WIDTH-1:0]     ld_data;
   logic [NREG_BITS-1:0] ld_idx;
   logic                 ld_wb, ld_flag_en, ld_cf, ld_of;

   assign load_mul    = (((state == ST_MUL) && mul_done) || (state == ST_MUL_DONE))
                        && out_free && !flush;
   assign load_single = accept && !is_mul;
   assign load        = load_mul || load_single;

   always_comb begin
      if (load_mul) begin
         ld_data    = mul_p[WIDTH-1:0];
         ld_idx     = mul_dst;
         ld_wb      = mul_wb;
         ld_flag_en = mul_flag_en;
         ld_cf      = |mul_p[2*WIDTH-1:WIDTH];
         ld_of      = |mul_p[2*WIDTH-1:WIDTH];
      end else begin
         ld_data    = alu_res;
         ld_idx     = dst_idx;
         ld_wb      = ctrl[CTRL_WB] && arch_op;
         ld_flag_en = ctrl[CTRL_FLAGS] && arch_op;
         ld_cf      = alu_cf;
         ld_of      = alu_of;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_dst     <= '0;
         mul_wb      <= 1'b0;
         mul_flag_en <= 1'b0;
      end else if (mul_start) begin
         mul_dst     <= dst_idx;
         mul_wb      <= ctrl[CTRL_WB];
         mul_flag_en <= ctrl[CTRL_FLAGS];
      end
   end

   // A flush drops the held packet even if it is being handshaken on this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_wb    <= 1'b0;
         out_widx  <= '0;
         out_wdata <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_wb    <= ld_wb;
         out_widx  <= ld_idx;
         out_wdata <= ld_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '0;
      end else if (load && ld_flag_en) begin
         flags <= pack_flags(ld_of, ld_data[WIDTH-1], (ld_data == '0), ld_cf);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (mul_start) state <= ST_MUL;
            ST_MUL:      if (mul_done) state <= out_free ? ST_IDLE : ST_MUL_DONE;
            ST_MUL_DONE: if (out_free) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage, checked against an
// arithmetic reference model of the opcode and flag rules.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush;
   logic        out_valid, out_ready, out_we;
   logic [6:0]  ctrl;
   logic [31:0] op_a, op_b, out_wdata;
   logic [2:0]  dst_idx, out_widx;
   logic [3:0]  flags;

   int          vectors = 0;
   int          miscompares = 0;
   logic [3:0]  exp_flags;

   execute_stage dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ctrl     (ctrl),
      .op_a     (op_a),
      .op_b     (op_b),
      .dst_idx  (dst_idx),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_we   (out_we),
      .out_widx (out_widx),
      .out_wdata(out_wdata),
      .flags    (flags)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference: true-value arithmetic, overflow from widened signed sums,
   // shifts done one bit at a time remembering what fell off the end.
   function automatic void model(input logic [6:0] c, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output logic we, output logic upd,
                                 output logic [3:0] f);
      logic [3:0]  opc;
      logic [63:0] u;
      longint      s;
      logic        cf, of;
      opc = c[3:0];
      we  = c[5] && (opc <= 4'd9);
      upd = c[4] && (opc <= 4'd9);
      cf  = 1'b0;
      of  = 1'b0;
      res = '0;
      case (opc)
         4'd0: begin
            u   = 64'(a) + 64'(b);
            res = u[31:0];
            cf  = (u > 64'h0000_0000_FFFF_FFFF);
            s   = longint'($signed(a)) + longint'($signed(b));
            of  = (s != longint'($signed(res)));
         end
         4'd1: begin
            res = a - b;
            cf  = (a < b);
            s   = longint'($signed(a)) - longint'($signed(b));
            of  = (s != longint'($signed(res)));
         end
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5, 4'd6, 4'd7: begin
            res = a;
            for (int k = 0; k < int'(b[4:0]); k++) begin
               if (opc == 4'd5) begin
                  cf  = res[31];
                  res = res << 1;
               end else begin
                  cf  = res[0];
                  res = {(opc == 4'd7) ? res[31] : 1'b0, res[31:1]};
               end
            end
         end
         4'd8: begin
            u   = 64'(a) * 64'(b);
            res = u[31:0];
            cf  = (u[63:32] != 32'd0);
            of  = cf;
         end
         4'd9: res = b;
         default: res = '0;
      endcase
      f = {of, res[31], (res == 32'd0), cf};
   endfunction

   task automatic checkPacket(input string tag, input logic [31:0] wd,
                              input logic we, input logic [2:0] idx);
      checkOutput({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
      checkOutput({tag, ".we"},    64'(out_we),    64'(we));
      checkOutput({tag, ".widx"},  64'(out_widx),  64'(idx));
      checkOutput({tag, ".wdata"}, 64'(out_wdata), 64'(wd));
      checkOutput({tag, ".flags"}, 64'(flags),     64'(exp_flags));
   endtask

   // Present one op at the next falling edge; returns #1 after its accept edge.
   task automatic applyStimulus(input string tag, input logic [6:0] c,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] d);
      @(negedge clk);
      ctrl = c; op_a = a; op_b = b; dst_idx = d; in_valid = 1'b1;
      #1;
      checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(1'b1));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [6:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] d);
      logic [31:0] res;
      logic        we, upd;
      logic [3:0]  f;
      int          n, busy_hi;
      model(c, a, b, res, we, upd, f);
      applyStimulus(tag, c, a, b, d);
      if (c[3:0] == 4'd8) begin
         n = 0;
         busy_hi = 0;
         while (!out_valid && n < 40) begin
            if (in_ready) busy_hi++;
            @(posedge clk);
            #1 n++;
         end
         checkOutput({tag, ".mul_latency"}, 64'(n), 64'(32));
         checkOutput({tag, ".mul_in_ready_high"}, 64'(busy_hi), 64'(0));
      end
      if (upd) exp_flags = f;
      checkPacket(tag, res, we, d);
   endtask

   initial begin
      logic [31:0] res, res2;
      logic        we, we2, upd;
      logic [3:0]  f;
      int          seen;

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      ctrl = '0; op_a = '0; op_b = '0; dst_idx = '0; exp_flags = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.in_ready",  64'(in_ready),  64'(1'b0));
      checkOutput("rst.out_valid", 64'(out_valid), 64'(1'b0));
      checkOutput("rst.flags",     64'(flags),     64'(4'b0000));
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1 checkOutput("post_rst.in_ready", 64'(in_ready), 64'(1'b1));

      runOp("add", 7'h30, 32'hAAAAAAAA, 32'hCAFEBABE, 3'd0);
      checkOutput("add.const_wdata", 64'(out_wdata), 64'(32'h75A96568));
      checkOutput("add.const_flags", 64'(flags), 64'(4'b1001));
      runOp("sub_eq", 7'h31, 32'd5, 32'd5, 3'd1);
      checkOutput("sub_eq.const_flags", 64'(flags), 64'(4'b0010));
      runOp("sub_neg", 7'h31, 32'd0, 32'd1, 3'd2);
      checkOutput("sub_neg.const_wdata", 64'(out_wdata), 64'(32'hFFFFFFFF));
      checkOutput("sub_neg.const_flags", 64'(flags), 64'(4'b0101));
      runOp("mul_big", 7'h38, 32'h00010000, 32'h00010000, 3'd3);
      checkOutput("mul_big.const_flags", 64'(flags), 64'(4'b1011));
      runOp("mul_small", 7'h38, 32'h1234, 32'h10, 3'd4);
      checkOutput("mul_small.const_wdata", 64'(out_wdata), 64'(32'h12340));
      checkOutput("mul_small.const_flags", 64'(flags), 64'(4'b0000));

      // Back-to-back single-cycle ops at full throughput
      @(negedge clk);
      ctrl = 7'h34; op_a = 32'hF0F0_1234; op_b = 32'hFFFF_0000; dst_idx = 3'd5; in_valid = 1'b1;
      #1 checkOutput("tput1.in_ready", 64'(in_ready), 64'(1'b1));
      @(posedge clk);
      #1;
      model(ctrl, op_a, op_b, res, we, upd, f);
      if (upd) exp_flags = f;
      checkPacket("tput1", res, we, 3'd5);
      ctrl = 7'h35; op_a = 32'h8000_0001; op_b = 32'd1; dst_idx = 3'd6;
      @(negedge clk) checkOutput("tput2.in_ready", 64'(in_ready), 64'(1'b1));
      @(posedge clk);
      #1 in_valid = 1'b0;
      model(ctrl, op_a, op_b, res, we, upd, f);
      if (upd) exp_flags = f;
      checkPacket("tput2", res, we, 3'd6);
      @(posedge clk);
      #1 checkOutput("tput.drained", 64'(out_valid), 64'(1'b0));

      // Backpressure: ADD held, MOV waits, then both drain in order
      @(negedge clk);
      out_ready = 1'b0;
      ctrl = 7'h30; op_a = 32'd1; op_b = 32'd2; dst_idx = 3'd5; in_valid = 1'b1;
      @(posedge clk);
      #1;
      model(ctrl, op_a, op_b, res, we, upd, f);
      if (upd) exp_flags = f;
      ctrl = 7'h29; op_a = 32'd0; op_b = 32'hDEADBEEF; dst_idx = 3'd6;
      model(ctrl, op_a, op_b, res2, we2, upd, f);
      repeat (3) begin
         @(negedge clk);
         checkOutput("bp.in_ready", 64'(in_ready), 64'(1'b0));
         checkPacket("bp.hold", res, we, 3'd5);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 checkOutput("bp.release_in_ready", 64'(in_ready), 64'(1'b1));
      @(posedge clk);
      #1 in_valid = 1'b0;
      checkPacket("bp.mov", res2, we2, 3'd6);
      @(posedge clk);
      #1 checkOutput("bp.drained", 64'(out_valid), 64'(1'b0));

      // Multiply completing while downstream is stalled
      @(negedge clk) out_ready = 1'b0;
      runOp("mul_bp", 7'h38, 32'd7, 32'd9, 3'd7);
      repeat (3) begin
         @(negedge clk);
         checkOutput("mul_bp.in_ready", 64'(in_ready), 64'(1'b0));
         checkPacket("mul_bp.hold", 32'd63, 1'b1, 3'd7);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 checkOutput("mul_bp.drained", 64'(out_valid), 64'(1'b0));

      // Flush in the middle of a multiply
      applyStimulus("fl_mul", 7'h38, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      ctrl = 7'h30; op_a = 32'd3; op_b = 32'd4; dst_idx = 3'd2; in_valid = 1'b1;
      #1 checkOutput("fl_mul.in_ready", 64'(in_ready), 64'(1'b0));
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("fl_mul.no_packet", 64'(seen), 64'(0));
      checkOutput("fl_mul.flags", 64'(flags), 64'(exp_flags));
      checkOutput("fl_mul.in_ready", 64'(in_ready), 64'(1'b1));

      // Flush drops a packet stuck behind backpressure
      @(negedge clk);
      out_ready = 1'b0;
      ctrl = 7'h33; op_a = 32'h8000_0000; op_b = 32'd1; dst_idx = 3'd2; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      model(ctrl, op_a, op_b, res, we, upd, f);
      if (upd) exp_flags = f;
      checkPacket("fl_out.held", res, we, 3'd2);
      @(negedge clk);
      flush = 1'b1;
      ctrl = 7'h30; in_valid = 1'b1;
      #1 checkOutput("fl_out.in_ready", 64'(in_ready), 64'(1'b0));
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      checkOutput("fl_out.valid", 64'(out_valid), 64'(1'b0));
      checkOutput("fl_out.we", 64'(out_we), 64'(1'b0));
      @(posedge clk);
      #1 checkOutput("fl_out.no_accept", 64'(out_valid), 64'(1'b0));
      checkOutput("fl_out.flags", 64'(flags), 64'(exp_flags));
      @(negedge clk) out_ready = 1'b1;

      // Asynchronous reset in the middle of a multiply
      applyStimulus("rst_mul", 7'h38, 32'd3, 32'd5, 3'd1);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_mul.out_valid", 64'(out_valid), 64'(1'b0));
      checkOutput("rst_mul.out_wdata", 64'(out_wdata), 64'(32'd0));
      checkOutput("rst_mul.out_widx",  64'(out_widx),  64'(3'd0));
      checkOutput("rst_mul.flags",     64'(flags),     64'(4'b0000));
      checkOutput("rst_mul.in_ready",  64'(in_ready),  64'(1'b0));
      exp_flags = '0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1 checkOutput("rst_mul.in_ready_after", 64'(in_ready), 64'(1'b1));

      // Randomized ops, multiply roughly one time in ten
      for (int i = 0; i < 150; i++) begin
         logic [3:0]  opc;
         logic [2:0]  hi, d;
         logic [31:0] a, b;
         opc = ($urandom_range(0, 9) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         hi  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         d   = 3'($urandom_range(0, 7));
         runOp("rand", {hi, opc}, a, b, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
